// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG tone scheduler slice.
package psg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SLOT0,
        S_SLOT1,
        S_SLOT2,
        S_DONE
    } sched_state_t;

    localparam int          NUM_TONE_CH  = 3;
    localparam logic [3:0]  ATTEN_SILENT = 4'hF;
    localparam int          FREQ_W       = 10;

endpackage

// File: rtl/psg_tone_scheduler_if.sv
// Register-write bus from the PSG command decoder into the tone scheduler.
interface psg_tone_scheduler_if;
    import psg_pkg::*;

    logic [NUM_TONE_CH-1:0] enable;
    logic [FREQ_W-1:0]      freq;
    logic [NUM_TONE_CH-1:0] atten_enable;
    logic [3:0]             atten_mag;

    modport master (
        output enable,
        output freq,
        output atten_enable,
        output atten_mag
    );

    modport slave (
        input enable,
        input freq,
        input atten_enable,
        input atten_mag
    );

endinterface

// File: rtl/psg_prescaler.sv
// Free-running clock divider; tick marks the last clk cycle of each PSG tick period.
module psg_prescaler #(
    parameter int DIV_LOG2 = 4
) (
    input  logic clk,
    input  logic reset_N,
    output logic tick
);

    logic [DIV_LOG2-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = &count;

endmodule

// File: rtl/psg_tone_scheduler.sv
// Three-channel tone generator sharing one down-counter across round-robin slots.
module psg_tone_scheduler
    import psg_pkg::*;
#(
    parameter int DIV_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    reset_N,
    psg_tone_scheduler_if.slave     wr,
    output logic [NUM_TONE_CH-1:0]  tone_out,
    output logic [3:0]              amp0,
    output logic [3:0]              amp1,
    output logic [3:0]              amp2,
    output logic                    sample_strobe
);

    logic              tick;
    sched_state_t      state;
    sched_state_t      state_next;
    logic              slot_active;
    logic [1:0]        slot_idx;
    logic              amp_load;

    logic [FREQ_W-1:0] freq_reg  [NUM_TONE_CH];
    logic [3:0]        atten_reg [NUM_TONE_CH];
    logic [FREQ_W-1:0] cnt       [NUM_TONE_CH];

    logic [FREQ_W-1:0] sel_cnt;
    logic [FREQ_W-1:0] sel_freq;
    logic              sel_tone;
    logic              reload;
    logic [FREQ_W-1:0] next_cnt;
    logic              next_tone;

    psg_prescaler #(.DIV_LOG2(DIV_LOG2)) u_prescaler (
        .clk     (clk),
        .reset_N (reset_N),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        slot_active = 1'b0;
        slot_idx    = 2'd0;
        amp_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_next = S_SLOT0;
                end
            end
            S_SLOT0: begin
                slot_active = 1'b1;
                slot_idx    = 2'd0;
                state_next  = S_SLOT1;
            end
            S_SLOT1: begin
                slot_active = 1'b1;
                slot_idx    = 2'd1;
                state_next  = S_SLOT2;
            end
            S_SLOT2: begin
                slot_active = 1'b1;
                slot_idx    = 2'd2;
                state_next  = S_DONE;
            end
            S_DONE: begin
                amp_load   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single shared decrementer: operands are muxed in by the active slot index.
    always_comb begin
        sel_cnt  = cnt[0];
        sel_freq = freq_reg[0];
        sel_tone = tone_out[0];
        case (slot_idx)
            2'd1: begin
                sel_cnt  = cnt[1];
                sel_freq = freq_reg[1];
                sel_tone = tone_out[1];
            end
            2'd2: begin
                sel_cnt  = cnt[2];
                sel_freq = freq_reg[2];
                sel_tone = tone_out[2];
            end
            default: ;
        endcase
        reload    = (sel_cnt <= 10'd1);
        next_cnt  = reload ? sel_freq : (sel_cnt - 10'd1);
        next_tone = (sel_freq <= 10'd1) ? 1'b1 : ~sel_tone;
    end

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            for (int unsigned i = 0; i < NUM_TONE_CH; i++) begin
                freq_reg[i]  <= '0;
                atten_reg[i] <= ATTEN_SILENT;
                cnt[i]       <= '0;
            end
            tone_out      <= '0;
            amp0          <= '0;
            amp1          <= '0;
            amp2          <= '0;
            sample_strobe <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_TONE_CH; i++) begin
                if (wr.enable[i]) begin
                    freq_reg[i] <= wr.freq;
                end
                if (wr.atten_enable[i]) begin
                    atten_reg[i] <= wr.atten_mag;
                end
                if (slot_active && (slot_idx == i[1:0])) begin
                    cnt[i] <= next_cnt;
                    if (reload) begin
                        tone_out[i] <= next_tone;
                    end
                end
            end
            if (amp_load) begin
                amp0 <= tone_out[0] ? (ATTEN_SILENT - atten_reg[0]) : 4'h0;
                amp1 <= tone_out[1] ? (ATTEN_SILENT - atten_reg[1]) : 4'h0;
                amp2 <= tone_out[2] ? (ATTEN_SILENT - atten_reg[2]) : 4'h0;
            end
            sample_strobe <= amp_load;
        end
    end

endmodule

// File: tb/tb_psg_tone_scheduler.sv
// Randomized and directed bench for psg_tone_scheduler against a tick-phase reference model.
module tb_psg_tone_scheduler;
    import psg_pkg::*;

    localparam int DIV_LOG2 = 3;
    localparam int P        = 8;

    logic       clk = 1'b0;
    logic       reset_N = 1'b0;
    logic [2:0] tone_out;
    logic [3:0] amp0, amp1, amp2;
    logic       sample_strobe;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    psg_tone_scheduler_if bus ();

    psg_tone_scheduler #(.DIV_LOG2(DIV_LOG2)) dut (
        .clk           (clk),
        .reset_N       (reset_N),
        .wr            (bus),
        .tone_out      (tone_out),
        .amp0          (amp0),
        .amp1          (amp1),
        .amp2          (amp2),
        .sample_strobe (sample_strobe)
    );

    // Reference model: m_c counts cycles since reset release; slots fall on phases 0..2 after the first tick.
    int unsigned m_c;
    int          m_freq [3];
    int          m_atten[3];
    int          m_cnt  [3];
    bit   [2:0]  m_tone;
    int          m_amp  [3];
    bit          m_strobe;
    bit          model_valid = 1'b0;
    int          m_ph;

    always @(posedge clk) begin
        if (!reset_N) begin
            for (int ch = 0; ch < 3; ch++) begin
                m_freq[ch] = 0; m_atten[ch] = 15; m_cnt[ch] = 0; m_amp[ch] = 0;
            end
            m_tone = 3'b000; m_strobe = 1'b0; m_c = 0; model_valid = 1'b1;
        end else begin
            m_ph = int'(m_c % P);
            if (m_c >= P && m_ph < 3) begin
                if (m_cnt[m_ph] <= 1) begin
                    m_cnt[m_ph] = m_freq[m_ph];
                    m_tone[m_ph] = (m_freq[m_ph] <= 1) ? 1'b1 : !m_tone[m_ph];
                end else begin
                    m_cnt[m_ph] = m_cnt[m_ph] - 1;
                end
            end
            m_strobe = (m_c >= P && m_ph == 3);
            if (m_strobe)
                for (int ch = 0; ch < 3; ch++) m_amp[ch] = m_tone[ch] ? 15 - m_atten[ch] : 0;
            for (int ch = 0; ch < 3; ch++) begin
                if (bus.enable[ch])       m_freq[ch]  = int'(bus.freq);
                if (bus.atten_enable[ch]) m_atten[ch] = int'(bus.atten_mag);
            end
            m_c++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("tone_out", int'(tone_out), int'(m_tone));
            chk("amp0", int'(amp0), m_amp[0]);
            chk("amp1", int'(amp1), m_amp[1]);
            chk("amp2", int'(amp2), m_amp[2]);
            chk("sample_strobe", int'(sample_strobe), int'(m_strobe));
            if (reset_N && dut.tick)
                chk("tick_only_in_idle", int'(dut.state), int'(S_IDLE));
        end
    end

    task automatic drive(input logic [2:0] en, input logic [9:0] f,
                         input logic [2:0] aen, input logic [3:0] a);
        @(negedge clk);
        bus.enable = en; bus.freq = f; bus.atten_enable = aen; bus.atten_mag = a;
        @(negedge clk);
        bus.enable = 3'b000; bus.atten_enable = 3'b000;
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sample_strobe && cyc < 200);
        if (!sample_strobe) chk("strobe_timeout", 0, 1);
    endtask

    task automatic strobes_to_toggle(input int b, output int n);
        logic ref_v;
        int   cyc;
        ref_v = tone_out[b];
        n = 0;
        do begin
            wait_strobe(cyc);
            n++;
        end while (tone_out[b] == ref_v && n < 1100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    int  cyc, n;
    bit  found;

    initial begin
        bus.enable = '0; bus.freq = '0; bus.atten_enable = '0; bus.atten_mag = '0;
        reset_N = 1'b0;
        repeat (5) @(negedge clk);
        reset_N = 1'b1;

        // Reset / idle rate
        wait_strobe(cyc);
        chk("first_strobe_latency", cyc, P + 4);
        chk("idle_tone_dc", int'(tone_out), 7);
        chk("idle_amp0_silent", int'(amp0), 0);
        wait_strobe(cyc);
        chk("strobe_spacing_a", cyc, P);
        wait_strobe(cyc);
        chk("strobe_spacing_b", cyc, P);

        // Tone period on ch0
        drive(3'b001, 10'd3, 3'b001, 4'h0);
        strobes_to_toggle(0, n);
        strobes_to_toggle(0, n);
        chk("ch0_half_period", n, 3);
        strobes_to_toggle(0, n);
        chk("ch0_half_period_b", n, 3);

        // Attenuation map on ch1
        wait_strobe(cyc);
        drive(3'b010, 10'd1, 3'b010, 4'h5);
        wait_strobe(cyc);
        chk("ch1_atten5", int'(amp1), 10);
        drive(3'b000, 10'd0, 3'b010, 4'hF);
        wait_strobe(cyc);
        chk("ch1_atten_silent", int'(amp1), 0);

        // Slot collision on ch2
        drive(3'b100, 10'd2, 3'b100, 4'h3);
        repeat (4) wait_strobe(cyc);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (m_c >= P && (m_c % P) == 2 && m_cnt[2] <= 1) found = 1'b1;
        end
        chk("collision_window_found", int'(found), 1);
        bus.enable = 3'b100; bus.freq = 10'd5;
        @(negedge clk);
        bus.enable = 3'b000;
        wait_strobe(cyc);
        strobes_to_toggle(2, n);
        chk("collision_old_reload", n, 2);
        strobes_to_toggle(2, n);
        chk("collision_new_reload", n, 5);

        // Randomized writes
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                bus.enable       = 3'($urandom_range(0, 7));
                bus.freq         = 10'($urandom_range(0, 6));
                bus.atten_enable = 3'($urandom_range(0, 7));
                bus.atten_mag    = 4'($urandom_range(0, 15));
            end else begin
                bus.enable = 3'b000; bus.atten_enable = 3'b000;
            end
        end
        bus.enable = 3'b000; bus.atten_enable = 3'b000;

        // Simultaneous multi-write, lockstep at max frequency value
        wait_strobe(cyc);
        drive(3'b111, 10'd1, 3'b111, 4'h0);
        repeat (10) wait_strobe(cyc);
        chk("all_dc_before_max", int'(tone_out), 7);
        drive(3'b111, 10'h3FF, 3'b000, 4'h0);
        strobes_to_toggle(0, n);
        chk("max_first_toggle", n, 1);
        chk("max_lockstep_low", int'(tone_out), 0);
        strobes_to_toggle(0, n);
        chk("max_half_period", n, 1023);
        chk("max_lockstep_high", int'(tone_out), 7);

        // Mid-operation reset during slot 1
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (m_c >= P && (m_c % P) == 1) found = 1'b1;
        end
        chk("slot1_window_found", int'(found), 1);
        reset_N = 1'b0;
        @(negedge clk);
        reset_N = 1'b1;
        chk("reset_state_idle", int'(dut.state), int'(S_IDLE));
        chk("reset_amp0", int'(amp0), 0);
        chk("reset_tone", int'(tone_out), 0);
        wait_strobe(cyc);
        chk("post_reset_strobe_latency", cyc, P + 4);
        chk("post_reset_amp1_silent", int'(amp1), 0);
        repeat (3) wait_strobe(cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psg_tone_scheduler.md
Name: psg_tone_scheduler

Overview:
Consumes the register-write pulses from the PSG command decoder: per-channel frequency and attenuation enables, with a shared 10-bit freq and 4-bit atten_mag bus. It holds the three tone channels' frequency and attenuation registers. It time-multiplexes a single shared 10-bit down-counter datapath across the three channels in round-robin slots, once per prescaled PSG tick, and produces per-channel 4-bit amplitudes plus a sample strobe for the downstream mixer/DAC.

Parameters:
DIV_LOG2, 4, log2 of clk cycles per PSG tick; legal range 3..8. The minimum of 3 guarantees the slot sequence completes before the next tick.

Ports:
clk  input  1  system clock
reset_N  input  1  synchronous, active-low reset
enable  input  3  one-hot freq-write pulse per tone channel (from decoder)
freq  input  10  frequency value, valid while any enable bit is high
atten_enable  input  3  one-hot attenuation-write pulse per channel
atten_mag  input  4  attenuation value, valid while any atten_enable bit is high
tone_out  output  3  current square-wave level per channel
amp0  output  4  channel 0 amplitude
amp1  output  4  channel 1 amplitude
amp2  output  4  channel 2 amplitude
sample_strobe  output  1  one-cycle pulse: amp0..2 were just updated

Behaviour:
- Interface: one clock `clk`. Reset `reset_N` is synchronous and active-low; it is sampled only on posedge clk.
- Reset values:
  - freq_reg[0..2]=0, atten_reg[0..2]=4'hF (silent), cnt[0..2]=0
  - tone_out=0, amp0..2=0, sample_strobe=0
  - prescaler=0, state=S_IDLE
- Prescaler: free-running DIV_LOG2-bit counter. tick=1 when it equals all-ones, so the period P=2^DIV_LOG2 clk cycles.
- Register writes take effect at the clk edge where the pulse is high.
  - enable[i] loads freq_reg[i]<=freq; atten_enable[i] loads atten_reg[i]<=atten_mag.
  - Multiple bits set: every flagged channel is written.
  - A freq write does not touch cnt[i] or tone_out[i].
- FSM states: S_IDLE, S_SLOT0, S_SLOT1, S_SLOT2, S_DONE.
  - S_IDLE goes to S_SLOT0 when tick=1; otherwise it stays in S_IDLE.
  - S_SLOT0 -> S_SLOT1 -> S_SLOT2 -> S_DONE -> S_IDLE unconditionally, one cycle each.
  - tick is only honoured in S_IDLE. With legal DIV_LOG2, tick never arrives outside S_IDLE; the bench asserts this.
- Slot i (shared decrementer, uses the freq_reg[i] value registered before this edge):
  - If cnt[i] <= 1: cnt[i] <= freq_reg[i].
    - If freq_reg[i] <= 1, tone_out[i] <= 1 (held high; DC).
    - Otherwise tone_out[i] toggles.
  - Else: cnt[i] <= cnt[i]-1 (10-bit, no wrap possible).
  - Result: each half-period is freq_reg ticks; the full period is 2*freq_reg*P clk cycles.
- Write to channel i in the same cycle as slot i: the slot uses the old freq_reg; the new value is used from the next reload.
- S_DONE edge:
  - amp_i <= tone_out[i] ? (4'hF - atten_reg[i]) : 4'h0.
  - sample_strobe <= 1 at the same edge, so the strobe is high for exactly the one cycle in which the new amps first appear.
  - sample_strobe <= 0 at all other edges.
- Amplitudes change only at S_DONE. Attenuation writes become audible at the next sample.
- Reset mid-sequence (any state): all registers return to reset values on that edge; no partial slot update is retained.
- Sample rate: exactly one sample_strobe every P cycles. The first strobe comes 4 cycles after the first tick.

Decomposition:
- Package psg_pkg:
  - typedef enum logic [2:0] sched_state_t {S_IDLE, S_SLOT0, S_SLOT1, S_SLOT2, S_DONE}
  - localparam NUM_TONE_CH=3
  - localparam ATTEN_SILENT=4'hF
  - localparam FREQ_W=10
- One sub-module, psg_prescaler: DIV_LOG2 counter with tick output and synchronous active-low reset. Everything else is inline.
- The decrementer is a single shared instance, selected by slot index, not one per channel.

Test Plan:
- Reset / idle rate: DIV_LOG2=3, hold reset_N=0 for 5 cycles, release, no writes -> amp0..2=0, tone_out=3'b111 after first slot pass (freq 0 => DC high), amps stay 0 (atten silent), sample_strobe exactly every 8 cycles.
- Tone period: write freq=3 to ch0 (enable=001), atten 0 to ch0 (atten_enable=001, atten_mag=0) -> amp0 alternates 4'hF/4'h0 every 3 strobes (48-cycle period); amp1/amp2 stay 0.
- Attenuation map: ch1 freq=1 (DC), atten_mag=4'h5 -> amp1=4'hA from next strobe; then atten_mag=4'hF -> amp1=0 at following strobe.
- Slot collision: while ch2 runs freq=2, write freq=5 to ch2 in the S_SLOT2 cycle of a reload -> that reload loads 2; the next reload loads 5; the half-period changes from 2 to 5 strobes.
- Simultaneous multi-write: enable=3'b111, freq=10'h3FF -> all three freq_reg=1023; all channels toggle in lockstep every 1023 strobes; cnt never underflows.
- Mid-operation reset: assert reset_N=0 during S_SLOT1 -> next cycle state=S_IDLE, all amps 0, atten_reg=F, sample_strobe low until the first post-reset tick + 4 cycles.
